mem_ctrl_queue: RTL and testbench

Next-generation load/store unit front end for the LoongArch pipeline. It keeps up to DEPTH memory requests outstanding on the MMU bus, using split addr_ok/data_ok handshakes, and returns results strictly in program order. Load data is aligned and sign- or zero-extended here, so the writeback stage receives final register values. Exceptions (ALE, TLBR, PIL, PIS, PPI, PME) are detected at issue and carried in order with the request.

---
 rtl/mem_ctrl_queue.sv | 233 +++++++++++++++++++++++
 tb/tb_mem_ctrl_queue.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_queue.sv
// In-order load/store queue with split addr_ok/data_ok bus handshakes and load extension.
// Optional MEMCTRL_PERF_EN adds perf_req_cnt/perf_stall_cnt outputs.
module mem_ctrl_queue #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_type,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_exc,
  output logic [2:0]        resp_exc_code,
  output logic [ADDR_W-1:0] resp_badv,
  output logic              mmu_valid,
  output logic              mmu_we,
  output logic [ADDR_W-1:0] mmu_addr,
  output logic [1:0]        mmu_size,
  output logic [3:0]        mmu_wstrb,
  output logic [31:0]       mmu_wdata,
  input  logic              mmu_addr_ok,
  input  logic              mmu_data_ok,
  input  logic [31:0]       mmu_rdata,
  input  logic              mmu_tlbr,
  input  logic              mmu_pil,
  input  logic              mmu_pis,
  input  logic              mmu_ppi,
  input  logic              mmu_pme
`ifdef MEMCTRL_PERF_EN
  ,
  output logic [31:0]       perf_req_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned DSC_W = $clog2(2 * DEPTH);

  typedef struct packed {
    logic [1:0]        size;
    logic              sgn;
    logic [1:0]        off;
    logic              is_load;
    logic              exc;
    logic [2:0]        code;
    logic [ADDR_W-1:0] badv;
    logic              bus;
    logic              done;
    logic [31:0]       data;
  } entry_t;

  entry_t            ent_q [DEPTH];
  entry_t            ent_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DSC_W-1:0]  discard_q, discard_d;

  logic              is_ld, is_st, is_mem, ale, exc;
  logic [2:0]        code;
  logic              full, blocked, push, pop, take_data;
  logic              dhit;
  logic [PTR_W-1:0]  dptr, scan_idx;
  logic [CNT_W-1:0]  pend_cnt;
  logic [31:0]       ld_shift, ld_val;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sg);
    case (sz)
      2'd0:    return {{24{sg & w[7]}}, w[7:0]};
      2'd1:    return {{16{sg & w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  always_comb begin
    is_ld  = (req_type == 2'd1);
    is_st  = (req_type == 2'd2);
    is_mem = is_ld | is_st;
    ale    = ((req_size == 2'd1) && req_addr[0]) ||
             ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
    code   = 3'd0;
    if (is_mem) begin
      if (ale)           code = 3'd1;
      else if (mmu_tlbr) code = 3'd2;
      else if (mmu_pil)  code = 3'd3;
      else if (mmu_pis)  code = 3'd4;
      else if (mmu_ppi)  code = 3'd5;
      else if (mmu_pme)  code = 3'd6;
    end
    exc = (code != 3'd0);
  end

  // Counter holds up to 2*DEPTH-1 bus transactions; ">=" keeps the block active if it ever reaches DEPTH or beyond.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign blocked   = (discard_q >= DSC_W'(DEPTH));
  assign mmu_valid = req_valid & ~full & is_mem & ~exc & ~flush & ~blocked;
  assign req_ready = req_valid & ~full & ~flush & (~is_mem | exc | (mmu_addr_ok & ~blocked));
  assign mmu_we    = is_st;
  assign mmu_addr  = req_addr;
  assign mmu_size  = req_size;

  always_comb begin
    mmu_wstrb = '0;
    mmu_wdata = req_wdata;
    case (req_size)
      2'd0: begin
        mmu_wdata = {4{req_wdata[7:0]}};
        if (is_st) mmu_wstrb = 4'b0001 << req_addr[1:0];
      end
      2'd1: begin
        mmu_wdata = {2{req_wdata[15:0]}};
        if (is_st) mmu_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: if (is_st) mmu_wstrb = 4'b1111;
    endcase
  end

  // Data pointer: oldest live entry still waiting on the bus, found by scanning from the head.
  always_comb begin
    dhit     = 1'b0;
    dptr     = head_q;
    pend_cnt = '0;
    scan_idx = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && ent_q[scan_idx].bus && !ent_q[scan_idx].done) begin
        pend_cnt = pend_cnt + 1'b1;
        if (!dhit) begin
          dhit = 1'b1;
          dptr = scan_idx;
        end
      end
    end
  end

  assign take_data = mmu_data_ok & (discard_q == '0) & dhit;
  assign ld_shift  = mmu_rdata >> {ent_q[dptr].off, 3'b000};
  assign ld_val    = load_ext(ld_shift, ent_q[dptr].size, ent_q[dptr].sgn);

  assign resp_valid    = (count_q != '0) & ent_q[head_q].done;
  assign resp_rdata    = ent_q[head_q].data;
  assign resp_exc      = ent_q[head_q].exc;
  assign resp_exc_code = ent_q[head_q].code;
  assign resp_badv     = ent_q[head_q].badv;

  assign push = req_ready;
  assign pop  = resp_valid & resp_ready;

  always_comb begin
    ent_d     = ent_q;
    head_d    = head_q;
    tail_d    = tail_q;
    discard_d = discard_q;
    if (take_data) begin
      ent_d[dptr].done = 1'b1;
      ent_d[dptr].data = ent_q[dptr].is_load ? ld_val : '0;
    end
    if (mmu_data_ok && (discard_q != '0)) discard_d = discard_q - 1'b1;
    if (pop) begin
      ent_d[head_q].bus  = 1'b0;
      ent_d[head_q].done = 1'b0;
      head_d             = head_q + 1'b1;
    end
    if (push) begin
      ent_d[tail_q].size    = req_size;
      ent_d[tail_q].sgn     = req_signed;
      ent_d[tail_q].off     = req_addr[1:0];
      ent_d[tail_q].is_load = is_ld;
      ent_d[tail_q].exc     = exc;
      ent_d[tail_q].code    = code;
      ent_d[tail_q].badv    = req_addr;
      ent_d[tail_q].bus     = is_mem & ~exc;
      ent_d[tail_q].done    = ~is_mem | exc;
      ent_d[tail_q].data    = '0;
      tail_d                = tail_q + 1'b1;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (flush) begin
      // An entry completed by data_ok this cycle no longer owes the bus a response.
      discard_d = discard_d + DSC_W'(pend_cnt) - DSC_W'(take_data);
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_d[i].bus  = 1'b0;
        ent_d[i].done = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      discard_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      discard_q <= discard_d;
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

`ifdef MEMCTRL_PERF_EN
  logic [31:0] perf_req_q, perf_stall_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_req_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (req_ready && is_mem)      perf_req_q   <= perf_req_q + 32'd1;
      if (req_valid && !req_ready)  perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_req_cnt   = perf_req_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_ctrl_queue.sv
// Self-checking bench for mem_ctrl_queue: directed scenarios plus random traffic
// compared every cycle against a queue-based behavioural model.
module tb_mem_ctrl_queue;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = 32;
  localparam logic [1:0] T_NOP = 2'd0, T_LD = 2'd1, T_ST = 2'd2;
  localparam logic [1:0] S_B = 2'd0, S_H = 2'd1, S_W = 2'd2;

  logic clk = 1'b0, resetn = 1'b0, flush = 1'b0;
  logic req_valid = 1'b0, req_signed = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [1:0] req_type = '0, req_size = '0;
  logic [31:0] req_wdata = '0;
  logic req_ready, resp_valid, resp_exc;
  logic resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic [2:0] resp_exc_code;
  logic [AW-1:0] resp_badv, mmu_addr;
  logic mmu_valid, mmu_we;
  logic [1:0] mmu_size;
  logic [3:0] mmu_wstrb;
  logic [31:0] mmu_wdata;
  logic mmu_addr_ok = 1'b0, mmu_data_ok = 1'b0;
  logic [31:0] mmu_rdata = '0;
  logic mmu_tlbr = 1'b0, mmu_pil = 1'b0, mmu_pis = 1'b0, mmu_ppi = 1'b0, mmu_pme = 1'b0;
`ifdef MEMCTRL_PERF_EN
  logic [31:0] perf_req_cnt, perf_stall_cnt;
`endif

  mem_ctrl_queue #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_type(req_type), .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_exc(resp_exc), .resp_exc_code(resp_exc_code), .resp_badv(resp_badv),
    .mmu_valid(mmu_valid), .mmu_we(mmu_we), .mmu_addr(mmu_addr), .mmu_size(mmu_size),
    .mmu_wstrb(mmu_wstrb), .mmu_wdata(mmu_wdata),
    .mmu_addr_ok(mmu_addr_ok), .mmu_data_ok(mmu_data_ok), .mmu_rdata(mmu_rdata),
    .mmu_tlbr(mmu_tlbr), .mmu_pil(mmu_pil), .mmu_pis(mmu_pis), .mmu_ppi(mmu_ppi),
    .mmu_pme(mmu_pme)
`ifdef MEMCTRL_PERF_EN
    , .perf_req_cnt(perf_req_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0, n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: program-order queue of requests plus a count of orphaned bus responses.
  typedef struct {
    bit        bus;
    bit        done;
    bit [31:0] data;
    bit [2:0]  code;
    bit [31:0] badv;
    bit        is_load;
    bit [1:0]  size;
    bit        sgn;
    bit [1:0]  off;
  } ment_t;

  ment_t       mq[$];
  int unsigned m_disc = 0;
  int unsigned m_preq = 0, m_pstall = 0;

  function automatic bit [31:0] ext(input bit [31:0] w, input bit [1:0] off,
                                    input bit [1:0] sz, input bit sg);
    bit [31:0] v;
    v = w >> (8 * off);
    if (sz == S_B) begin
      v = v & 32'h0000_00FF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == S_H) begin
      v = v & 32'h0000_FFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic bit [2:0] exp_code();
    bit misal;
    if (req_type != T_LD && req_type != T_ST) return 3'd0;
    misal = (req_size == S_H && (req_addr % 2) != 0) || (req_size == S_W && (req_addr % 4) != 0);
    if (misal)    return 3'd1;
    if (mmu_tlbr) return 3'd2;
    if (mmu_pil)  return 3'd3;
    if (mmu_pis)  return 3'd4;
    if (mmu_ppi)  return 3'd5;
    if (mmu_pme)  return 3'd6;
    return 3'd0;
  endfunction

  function automatic int unsigned outstanding();
    int unsigned n;
    n = m_disc;
    foreach (mq[i]) if (mq[i].bus && !mq[i].done) n++;
    return n;
  endfunction

  // One clock: called at a negedge with inputs already set; checks, then advances the model.
  task automatic step();
    bit        mem, e_mv, e_rdy, e_rv;
    bit [2:0]  c;
    bit [3:0]  e_strb;
    bit [31:0] e_wd;
    ment_t     e;
    #1;
    mem   = (req_type == T_LD) || (req_type == T_ST);
    c     = exp_code();
    e_mv  = req_valid && (mq.size() < DEPTH) && mem && (c == 0) && !flush && (m_disc < DEPTH);
    e_rdy = req_valid && (mq.size() < DEPTH) && !flush &&
            (!mem || c != 0 || (mmu_addr_ok && m_disc < DEPTH));
    e_rv  = (mq.size() > 0) && mq[0].done;
    check_eq("req_ready", {31'd0, req_ready}, {31'd0, e_rdy});
    check_eq("mmu_valid", {31'd0, mmu_valid}, {31'd0, e_mv});
    if (e_mv) begin
      e_strb = 4'b0000;
      e_wd   = req_wdata;
      if (req_size == S_B) e_wd = {4{req_wdata[7:0]}};
      if (req_size == S_H) e_wd = {2{req_wdata[15:0]}};
      if (req_type == T_ST) begin
        if (req_size == S_B)      e_strb = 4'b0001 << (req_addr % 4);
        else if (req_size == S_H) e_strb = 4'b0011 << (req_addr % 4);
        else                      e_strb = 4'b1111;
      end
      check_eq("mmu_we", {31'd0, mmu_we}, {31'd0, req_type == T_ST});
      check_eq("mmu_addr", mmu_addr, req_addr);
      check_eq("mmu_size", {30'd0, mmu_size}, {30'd0, req_size});
      check_eq("mmu_wstrb", {28'd0, mmu_wstrb}, {28'd0, e_strb});
      if (req_type == T_ST) check_eq("mmu_wdata", mmu_wdata, e_wd);
    end
    check_eq("resp_valid", {31'd0, resp_valid}, {31'd0, e_rv});
    if (e_rv) begin
      check_eq("resp_rdata", resp_rdata, mq[0].data);
      check_eq("resp_exc", {31'd0, resp_exc}, {31'd0, mq[0].code != 0});
      check_eq("resp_code", {29'd0, resp_exc_code}, {29'd0, mq[0].code});
      check_eq("resp_badv", resp_badv, mq[0].badv);
    end
`ifdef MEMCTRL_PERF_EN
    check_eq("perf_req", perf_req_cnt, m_preq);
    check_eq("perf_stall", perf_stall_cnt, m_pstall);
`endif
    @(posedge clk);
    if (mmu_data_ok) begin
      if (m_disc > 0) m_disc--;
      else begin
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].bus && !mq[i].done) begin
            e      = mq[i];
            e.done = 1'b1;
            e.data = e.is_load ? ext(mmu_rdata, e.off, e.size, e.sgn) : 32'd0;
            mq[i]  = e;
            break;
          end
        end
      end
    end
    if (e_rv && resp_ready) void'(mq.pop_front());
    if (e_rdy) begin
      e.bus     = mem && (c == 0);
      e.done    = !(mem && (c == 0));
      e.data    = 32'd0;
      e.code    = c;
      e.badv    = req_addr;
      e.is_load = (req_type == T_LD);
      e.size    = req_size;
      e.sgn     = req_signed;
      e.off     = 2'(req_addr % 4);
      mq.push_back(e);
    end
    if (flush) begin
      foreach (mq[i]) if (mq[i].bus && !mq[i].done) m_disc++;
      mq.delete();
    end
    if (e_rdy && mem) m_preq++;
    if (req_valid && !e_rdy) m_pstall++;
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    mmu_addr_ok = 1'b0; mmu_data_ok = 1'b0;
    {mmu_tlbr, mmu_pil, mmu_pis, mmu_ppi, mmu_pme} = '0;
  endtask

  task automatic set_req(input logic [1:0] t, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_type = t; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; mmu_addr_ok = 1'b1;
  endtask

  task automatic send(input string tag, input logic [1:0] t, input logic [1:0] sz,
                      input logic sg, input logic [31:0] a, input logic [31:0] wd);
    set_req(t, sz, sg, a, wd);
    #1 check_eq({tag, "_accept"}, {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0; mmu_addr_ok = 1'b0;
  endtask

  task automatic data(input logic [31:0] d);
    mmu_data_ok = 1'b1; mmu_rdata = d;
    step();
    mmu_data_ok = 1'b0;
  endtask

  task automatic take(input string tag, input logic [31:0] d, input logic [2:0] c,
                      input logic [31:0] badv);
    int unsigned n = 0;
    resp_ready = 1'b0;
    while (!resp_valid && n < 20) begin
      step();
      n++;
    end
    check_eq({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    check_eq({tag, "_data"}, resp_rdata, d);
    check_eq({tag, "_code"}, {29'd0, resp_exc_code}, {29'd0, c});
    check_eq({tag, "_exc"}, {31'd0, resp_exc}, {31'd0, c != 0});
    check_eq({tag, "_badv"}, resp_badv, badv);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned stall0;
    idle();
    repeat (3) @(negedge clk);
    check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_eq("rst_mmu_valid", {31'd0, mmu_valid}, 32'd0);
`ifdef MEMCTRL_PERF_EN
    check_eq("rst_perf_req", perf_req_cnt, 32'd0);
    check_eq("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif
    resetn = 1'b1;
    step();

    // Back-to-back word loads, data returned 3 cycles after each issue.
    send("ld0", T_LD, S_W, 1'b0, 32'h100, 32'd0);
    send("ld1", T_LD, S_W, 1'b0, 32'h104, 32'd0);
    step();
    data(32'h1111_1111);
    data(32'h2222_2222);
    take("ld0", 32'h1111_1111, 3'd0, 32'h100);
    take("ld1", 32'h2222_2222, 3'd0, 32'h104);

    // Byte load extension.
    send("lbs", T_LD, S_B, 1'b1, 32'h203, 32'd0);
    data(32'h80FF_FFFF);
    take("lbs", 32'hFFFF_FF80, 3'd0, 32'h203);
    send("lbu", T_LD, S_B, 1'b0, 32'h203, 32'd0);
    data(32'h80FF_FFFF);
    take("lbu", 32'h0000_0080, 3'd0, 32'h203);

    // Misaligned half store raises ALE without touching the bus.
    set_req(T_ST, S_H, 1'b0, 32'h1001, 32'hBEEF);
    #1 check_eq("ale_mmu_valid", {31'd0, mmu_valid}, 32'd0);
    check_eq("ale_accept", {31'd0, req_ready}, 32'd1);
    step();
    idle();
    take("ale", 32'd0, 3'd1, 32'h1001);

    // Aligned upper-half store.
    set_req(T_ST, S_H, 1'b0, 32'h1002, 32'hBEEF);
    #1 check_eq("sh_wstrb", {28'd0, mmu_wstrb}, 32'h0000_000C);
    check_eq("sh_wdata", mmu_wdata, 32'hBEEF_BEEF);
    step();
    idle();
    data(32'h1234_5678);
    take("sh", 32'd0, 3'd0, 32'h1002);

    // Queue full: third request stalls until the head pops.
    send("f0", T_LD, S_W, 1'b0, 32'h400, 32'd0);
    send("f1", T_LD, S_W, 1'b0, 32'h404, 32'd0);
    stall0 = m_pstall;
    set_req(T_LD, S_W, 1'b0, 32'h408, 32'd0);
    for (int unsigned i = 0; i < 3; i++) begin
      #1 check_eq("full_block", {31'd0, req_ready}, 32'd0);
      step();
    end
    mmu_data_ok = 1'b1; mmu_rdata = 32'hAAAA_0000;
    step();
    mmu_data_ok = 1'b0; resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    #1 check_eq("full_free_accept", {31'd0, req_ready}, 32'd1);
    step();
    idle();
    check_eq("stall_cycles", m_pstall - stall0, 32'd5);
`ifdef MEMCTRL_PERF_EN
    check_eq("perf_stall_cnt", perf_stall_cnt - stall0, 32'd5);
`endif
    data(32'hBBBB_0000);
    data(32'hCCCC_0000);
    take("f1", 32'hBBBB_0000, 3'd0, 32'h404);
    take("f2", 32'hCCCC_0000, 3'd0, 32'h408);

    // Flush with two loads in flight: their data is discarded.
    send("fl0", T_LD, S_W, 1'b0, 32'h500, 32'd0);
    send("fl1", T_LD, S_W, 1'b0, 32'h504, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    set_req(T_LD, S_W, 1'b0, 32'h300, 32'd0);
    #1 check_eq("disc_block_ready", {31'd0, req_ready}, 32'd0);
    check_eq("disc_block_mmu", {31'd0, mmu_valid}, 32'd0);
    step();
    idle();
    resp_ready = 1'b1;
    data(32'hDEAD_0001);
    data(32'hDEAD_0002);
    step();
    #1 check_eq("disc_no_resp", {31'd0, resp_valid}, 32'd0);
    resp_ready = 1'b0;
    send("ld300", T_LD, S_W, 1'b0, 32'h300, 32'd0);
    data(32'h3333_3333);
    take("ld300", 32'h3333_3333, 3'd0, 32'h300);

    // Random traffic against the model.
    for (int unsigned c = 0; c < 3000; c++) begin
      req_valid   = ($urandom_range(0, 3) != 0);
      req_type    = 2'($urandom_range(0, 2));
      req_size    = 2'($urandom_range(0, 2));
      req_signed  = 1'($urandom_range(0, 1));
      req_addr    = $urandom & 32'h0000_0FFF;
      req_wdata   = $urandom;
      mmu_tlbr    = ($urandom_range(0, 15) == 0);
      mmu_pil     = ($urandom_range(0, 15) == 0);
      mmu_pis     = ($urandom_range(0, 15) == 0);
      mmu_ppi     = ($urandom_range(0, 15) == 0);
      mmu_pme     = ($urandom_range(0, 15) == 0);
      mmu_addr_ok = 1'($urandom_range(0, 1));
      mmu_data_ok = (outstanding() > 0) && ($urandom_range(0, 2) == 0);
      mmu_rdata   = $urandom;
      resp_ready  = 1'($urandom_range(0, 1));
      flush       = ($urandom_range(0, 39) == 0);
      step();
    end
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
